// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle CPU main control FSM: state codes,
//   opcode values, datapath mux/ALU select codes and the bundled control-word
//   type that the FSM decodes from its state.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDI   = 4'd10,
        S_IMMWB  = 4'd11,
        S_HALT   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       halted;
    } ctl_t;

endpackage

// File: rtl/mc_state_reg.sv
// mc_state_reg
//   State register for the main control FSM.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous reset, active low; clears q to 0 (S_FETCH)
//     load  in   load enable for d
//     d     in   next state
//     q     out  current state
module mc_state_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm
//   Main control FSM of the multi-cycle CPU. Walks each instruction through
//   fetch/decode/execute/memory/writeback and drives every datapath enable and
//   mux select from the current state (Moore), except the FETCH PC/IR loads,
//   which also wait for the memory handshake.
//
//   state | meaning
//   ------+-----------------------------------------------
//   0     | FETCH   read instr at PC, PC+4, IR load on mem_ready
//   1     | DECODE  branch target precompute, opcode dispatch
//   2     | MEMADR  lw/sw effective address
//   3     | MEMRD   lw data read, waits on mem_ready
//   4     | MEMWB   lw write-back from MDR
//   5     | MEMWR   sw data write, waits on mem_ready
//   6     | RTYPE   ALU op from funct
//   7     | ALUWB   R-type write-back to rd
//   8     | BEQ     compare, conditional PC load
//   9     | JUMP    PC load from jump target
//   10    | ADDI    ALU add immediate
//   11    | IMMWB   addi write-back to rt
//   12    | HALT    sticky until reset
//   13-15 | unused, recover to FETCH
//
//   Ports:
//     clk, rst (async active low), opcode (IR[31:26]), mem_ready (in)
//     state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//     pc_source, instr_done, halted (out)
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W         = 4,
    parameter int OP_W            = 6,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               halted
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctl_t               ctl;
    ctl_t               ctl_out;

    mc_state_reg #(.W(STATE_W)) u_state_reg (
        .clk  (clk),
        .rst  (rst),
        .load (state_d != state_q),
        .d    (state_d),
        .q    (state_q)
    );

    always_comb begin
        state_d = S_FETCH;
        ctl     = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRC_B_FOUR;
                ctl.alu_op    = ALU_OP_ADD;
                ctl.pc_source = PC_SRC_ALU;
                ctl.pc_write  = mem_ready;
                ctl.ir_write  = mem_ready;
                state_d       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctl.alu_src_b = SRC_B_IMM_SH2;
                ctl.alu_op    = ALU_OP_ADD;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_RTYPE;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BEQ;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDI;
                end else begin
                    state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_OP_ADD;
                state_d       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                state_d      = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write  = 1'b1;
                ctl.iord       = 1'b1;
                // sw ends in its wait state, so the completion pulse must wait
                // for the handshake to stay a single cycle.
                ctl.instr_done = mem_ready;
                state_d        = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_REG;
                ctl.alu_op    = ALU_OP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_dst    = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRC_B_REG;
                ctl.alu_op        = ALU_OP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PC_SRC_ALUOUT;
                ctl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PC_SRC_JUMP;
                ctl.instr_done = 1'b1;
            end
            S_ADDI: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_OP_ADD;
                state_d       = S_IMMWB;
            end
            S_IMMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_HALT: begin
                ctl.halted = 1'b1;
                state_d    = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State 0 alone would still assert the FETCH controls; reset must silence
    // every output immediately, not just after the register clears.
    assign ctl_out = rst ? ctl : '0;

    assign state         = state_q;
    assign pc_write      = ctl_out.pc_write;
    assign pc_write_cond = ctl_out.pc_write_cond;
    assign iord          = ctl_out.iord;
    assign mem_read      = ctl_out.mem_read;
    assign mem_write     = ctl_out.mem_write;
    assign ir_write      = ctl_out.ir_write;
    assign mem_to_reg    = ctl_out.mem_to_reg;
    assign reg_dst       = ctl_out.reg_dst;
    assign reg_write     = ctl_out.reg_write;
    assign alu_src_a     = ctl_out.alu_src_a;
    assign alu_src_b     = ctl_out.alu_src_b;
    assign alu_op        = ctl_out.alu_op;
    assign pc_source     = ctl_out.pc_source;
    assign instr_done    = ctl_out.instr_done;
    assign halted        = ctl_out.halted;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       done;
        logic       halt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic [3:0] state;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, halted;
    logic [1:0] alu_src_b, alu_op, pc_source;

    logic [5:0] opcode1 = 6'h3f;
    logic       mem_ready1 = 1'b1;
    logic [3:0] state1;
    logic       pc_write1, pc_write_cond1, iord1, mem_read1, mem_write1, ir_write1;
    logic       mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, instr_done1, halted1;
    logic [1:0] alu_src_b1, alu_op1, pc_source1;

    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;
    exp_t exp_q[$];
    logic [5:0] cur_op = 6'd0;
    logic [5:0] opc [0:6];
    bit         prev_valid = 1'b0;
    logic [3:0] prev_s1 = 4'd0;

    mc_ctrl_fsm #(.STATE_W(4), .OP_W(6), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .state(state), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
        .halted(halted)
    );

    mc_ctrl_fsm #(.STATE_W(4), .OP_W(6), .HALT_ON_ILLEGAL(1'b0)) dut_nohalt (
        .clk(clk), .rst(rst), .opcode(opcode1), .mem_ready(mem_ready1),
        .state(state1), .pc_write(pc_write1), .pc_write_cond(pc_write_cond1),
        .iord(iord1), .mem_read(mem_read1), .mem_write(mem_write1),
        .ir_write(ir_write1), .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1),
        .reg_write(reg_write1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
        .alu_op(alu_op1), .pc_source(pc_source1), .instr_done(instr_done1),
        .halted(halted1)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual0();
        exp_t a;
        a = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, halted};
        return a;
    endfunction

    function automatic exp_t actual1();
        exp_t a;
        a = {state1, pc_write1, pc_write_cond1, iord1, mem_read1, mem_write1,
             ir_write1, mem_to_reg1, reg_dst1, reg_write1, alu_src_a1,
             alu_src_b1, alu_op1, pc_source1, instr_done1, halted1};
        return a;
    endfunction

    function automatic exp_t rec(input int s);
        exp_t e;
        e    = '0;
        e.st = 4'(s);
        return e;
    endfunction

    // Monitor: one expected record per clock period, compared mid-period.
    always @(negedge clk) begin
        exp_t a, e;
        cycle_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual0();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl_word cyc %0d actual %h required %h", cycle_no, a, e);
            end
        end
        // Second instance only ever sees an illegal opcode: it must bounce
        // between FETCH and DECODE and never halt.
        a = actual1();
        checks++;
        if (!rst) begin
            if (a !== '0) begin
                errors++;
                $display("FAIL nohalt_reset actual %h required 0", a);
            end
            prev_valid = 1'b0;
        end else begin
            if (halted1 !== 1'b0 || state1 > 4'd1 || (prev_valid && state1 == prev_s1)) begin
                errors++;
                $display("FAIL nohalt_loop actual state %0d halted %0d prev %0d", state1, halted1, prev_s1);
            end
            prev_valid = 1'b1;
            prev_s1    = state1;
        end
    end

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input bit mr, input exp_t e);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_ready = mr;
        opcode    = cur_op;
        exp_q.push_back(e);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst       = 1'b0;
            mem_ready = rnd();
            exp_q.push_back(rec(0));
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (actual0() !== '0) begin
            errors++;
            $display("FAIL async_reset actual %h required 0", actual0());
        end
        reset_cycles(2);
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 beq, 4 j, 5 addi, 6 illegal
    task automatic issue(input int kind, input int fw, input int mw, input bit abort);
        exp_t e;
        int   ws;
        cur_op = opc[kind];
        for (int i = 0; i < fw; i++) begin
            e = rec(0); e.mrd = 1'b1; e.srcb = 2'b01;
            cyc(1'b0, e);
        end
        e = rec(0); e.mrd = 1'b1; e.srcb = 2'b01; e.pcw = 1'b1; e.irw = 1'b1;
        cyc(1'b1, e);
        e = rec(1); e.srcb = 2'b11;
        cyc(rnd(), e);
        case (kind)
            0, 1: begin
                e = rec(2); e.srca = 1'b1; e.srcb = 2'b10;
                cyc(rnd(), e);
                ws = (kind == 0) ? 3 : 5;
                e = rec(ws); e.iord = 1'b1;
                if (kind == 0) e.mrd = 1'b1; else e.mwr = 1'b1;
                for (int i = 0; i < mw; i++) begin
                    cyc(1'b0, e);
                    if (abort) begin
                        mid_reset();
                        return;
                    end
                end
                if (kind == 1) e.done = 1'b1;
                cyc(1'b1, e);
                if (kind == 0) begin
                    e = rec(4); e.m2r = 1'b1; e.rw = 1'b1; e.done = 1'b1;
                    cyc(rnd(), e);
                end
            end
            2: begin
                e = rec(6); e.srca = 1'b1; e.aluop = 2'b10;
                cyc(rnd(), e);
                e = rec(7); e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1;
                cyc(rnd(), e);
            end
            3: begin
                e = rec(8); e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1;
                e.pcsrc = 2'b01; e.done = 1'b1;
                cyc(rnd(), e);
            end
            4: begin
                e = rec(9); e.pcw = 1'b1; e.pcsrc = 2'b10; e.done = 1'b1;
                cyc(rnd(), e);
            end
            5: begin
                e = rec(10); e.srca = 1'b1; e.srcb = 2'b10;
                cyc(rnd(), e);
                e = rec(11); e.rw = 1'b1; e.done = 1'b1;
                cyc(rnd(), e);
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    e = rec(12); e.halt = 1'b1;
                    cyc(rnd(), e);
                end
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        opc[0] = 6'b100011;
        opc[1] = 6'b101011;
        opc[2] = 6'b000000;
        opc[3] = 6'b000100;
        opc[4] = 6'b000010;
        opc[5] = 6'b001000;
        opc[6] = 6'b111111;

        reset_cycles(3);
        issue(0, 0, 0, 1'b0);   // lw, no waits
        issue(1, 0, 3, 1'b0);   // sw, 3 write waits
        issue(2, 2, 0, 1'b0);   // fetch stalled 2 cycles
        issue(3, 0, 0, 1'b0);   // beq
        issue(4, 1, 0, 1'b0);   // j
        issue(5, 0, 0, 1'b0);   // addi
        issue(0, 1, 2, 1'b0);   // lw with read waits
        for (int n = 0; n < 60; n++) begin
            issue(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'b0);
        end
        issue(0, 0, 2, 1'b1);   // reset while lw waits in MEMRD
        issue(2, 0, 0, 1'b0);   // normal operation after reset
        issue(6, 0, 0, 1'b0);   // illegal opcode -> sticky halt
        reset_cycles(2);
        issue(4, 0, 0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
